// File: rtl/nibble_class_stats.sv
// nibble_class_stats: saturating statistics over a classified nibble stream.
// Counts beats, primes, multiples of 3, both, and the longest prime run.
// On request it freezes input and reads a 5-word snapshot over a valid/ready
// report port. The statistics can optionally be cleared after the report.
module nibble_class_stats #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_val,
    input  logic          in_p,
    input  logic          in_d,
    input  logic          rpt_req,
    input  logic          rpt_clr,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic [2:0]    rpt_idx,
    output logic [CW-1:0] rpt_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SNAP, SEND, CLR} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Saturating increment: the counter sticks at all-ones and never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x, input logic en);
        return (en && (x != CNT_MAX)) ? x + CW'(1) : x;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] tot_q, tot_d, prm_q, prm_d, div_q, div_d, both_q, both_d;
    logic [CW-1:0] max_run_q, max_run_d, cur_run_q, cur_run_d;
    logic [CW-1:0] snap_q [0:4];
    logic [CW-1:0] snap_d [0:4];
    logic          clr_lat_q, clr_lat_d;
    logic          rpt_valid_q, rpt_valid_d;
    logic [2:0]    rpt_idx_q, rpt_idx_d;
    logic [CW-1:0] rpt_data_q, rpt_data_d;
    logic [2:0]    next_idx;
    logic [CW-1:0] run_inc;
    logic          accept;

    // in_val travels with the beat for debug visibility only.
    logic unused_in_val;
    assign unused_in_val = ^in_val;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign rpt_valid = rpt_valid_q;
    assign rpt_idx   = rpt_idx_q;
    assign rpt_data  = rpt_data_q;
    assign next_idx  = rpt_idx_q + 3'd1;
    assign run_inc   = sat_inc(cur_run_q, 1'b1);

    // Next-state logic for the FSM, the statistics and the report port.
    always_comb begin
        // NOTE: every *_d starts as its *_q so that no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        tot_d       = tot_q;
        prm_d       = prm_q;
        div_d       = div_q;
        both_d      = both_q;
        max_run_d   = max_run_q;
        cur_run_d   = cur_run_q;
        snap_d      = snap_q;
        clr_lat_d   = clr_lat_q;
        rpt_valid_d = rpt_valid_q;
        rpt_idx_d   = rpt_idx_q;
        rpt_data_d  = rpt_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tot_d  = sat_inc(tot_q, 1'b1);
                    prm_d  = sat_inc(prm_q, in_p);
                    div_d  = sat_inc(div_q, in_d);
                    both_d = sat_inc(both_q, in_p & in_d);
                    if (in_p) begin
                        cur_run_d = run_inc;
                        if (run_inc > max_run_q) max_run_d = run_inc;
                    end else begin
                        cur_run_d = '0;
                    end
                end
                if (rpt_req) begin
                    clr_lat_d = rpt_clr;
                    state_d   = SNAP;
                end
            end
            SNAP: begin
                snap_d[0]   = tot_q;
                snap_d[1]   = prm_q;
                snap_d[2]   = div_q;
                snap_d[3]   = both_q;
                snap_d[4]   = max_run_q;
                rpt_valid_d = 1'b1;
                rpt_idx_d   = 3'd0;
                rpt_data_d  = tot_q;
                state_d     = SEND;
            end
            SEND: begin
                if (rpt_ready) begin
                    if (rpt_idx_q == 3'd4) begin
                        rpt_valid_d = 1'b0;
                        rpt_idx_d   = 3'd0;
                        rpt_data_d  = '0;
                        state_d     = clr_lat_q ? CLR : IDLE;
                    end else begin
                        rpt_idx_d = next_idx;
                        case (next_idx)
                            3'd1:    rpt_data_d = snap_q[1];
                            3'd2:    rpt_data_d = snap_q[2];
                            3'd3:    rpt_data_d = snap_q[3];
                            default: rpt_data_d = snap_q[4];
                        endcase
                    end
                end
            end
            CLR: begin
                tot_d     = '0;
                prm_d     = '0;
                div_d     = '0;
                both_d    = '0;
                max_run_d = '0;
                cur_run_d = '0;
                clr_lat_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any report in flight without clearing partially.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tot_q       <= '0;
            prm_q       <= '0;
            div_q       <= '0;
            both_q      <= '0;
            max_run_q   <= '0;
            cur_run_q   <= '0;
            // NOTE: the snapshot array is small and must read as zero after reset, so it is reset like any flop.
            for (int i = 0; i < 5; i++) snap_q[i] <= '0;
            clr_lat_q   <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_idx_q   <= 3'd0;
            rpt_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            tot_q       <= tot_d;
            prm_q       <= prm_d;
            div_q       <= div_d;
            both_q      <= both_d;
            max_run_q   <= max_run_d;
            cur_run_q   <= cur_run_d;
            snap_q      <= snap_d;
            clr_lat_q   <= clr_lat_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_data_q  <= rpt_data_d;
        end
    end

endmodule

// File: tb/tb_nibble_class_stats.sv
// Directed bench for nibble_class_stats. Two instances (CW=8 and CW=4) see the
// same stimulus; the CW=4 copy checks saturation at 15.
module tb_nibble_class_stats;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_val = 4'd0;
    logic       in_p = 1'b0;
    logic       in_d = 1'b0;
    logic       rpt_req = 1'b0;
    logic       rpt_clr = 1'b0;
    logic       rpt_ready = 1'b0;

    logic       in_ready8, rpt_valid8, busy8;
    logic [2:0] rpt_idx8;
    logic [7:0] rpt_data8;
    logic       in_ready4, rpt_valid4, busy4;
    logic [2:0] rpt_idx4;
    logic [3:0] rpt_data4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nibble_class_stats #(.CW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_val(in_val), .in_p(in_p), .in_d(in_d), .rpt_req(rpt_req),
        .rpt_clr(rpt_clr), .rpt_valid(rpt_valid8), .rpt_ready(rpt_ready),
        .rpt_idx(rpt_idx8), .rpt_data(rpt_data8), .busy(busy8)
    );

    nibble_class_stats #(.CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_val(in_val), .in_p(in_p), .in_d(in_d), .rpt_req(rpt_req),
        .rpt_clr(rpt_clr), .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready),
        .rpt_idx(rpt_idx4), .rpt_data(rpt_data4), .busy(busy4)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_ctl(input string tag, input int valid, input int busy, input int rdy);
        check({tag, " valid8"}, int'(rpt_valid8), valid);
        check({tag, " valid4"}, int'(rpt_valid4), valid);
        check({tag, " busy8"},  int'(busy8), busy);
        check({tag, " busy4"},  int'(busy4), busy);
        check({tag, " ready8"}, int'(in_ready8), rdy);
        check({tag, " ready4"}, int'(in_ready4), rdy);
    endtask

    task automatic check_word(input string tag, input int idx, input int exp8);
        check($sformatf("%s idx8[%0d]", tag, idx),  int'(rpt_idx8), idx);
        check($sformatf("%s idx4[%0d]", tag, idx),  int'(rpt_idx4), idx);
        check($sformatf("%s data8[%0d]", tag, idx), int'(rpt_data8), exp8);
        check($sformatf("%s data4[%0d]", tag, idx), int'(rpt_data4), sat4(exp8));
    endtask

    task automatic send_beat(input logic [3:0] v, input logic p, input logic d);
        in_valid = 1'b1; in_val = v; in_p = p; in_d = d;
        step();
        in_valid = 1'b0; in_p = 1'b0; in_d = 1'b0;
    endtask

    // Full report; optional stall at stall_idx and optional beat in the request cycle.
    task automatic read_report(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input int e4, input logic clr, input int stall_idx,
                               input logic beat, input logic bp, input logic bd);
        int exp [5];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
        rpt_req = 1'b1; rpt_clr = clr; rpt_ready = 1'b1;
        if (beat) begin
            in_valid = 1'b1; in_val = 4'd5; in_p = bp; in_d = bd;
        end
        step();
        rpt_req = 1'b0; rpt_clr = 1'b0;
        in_valid = 1'b0; in_p = 1'b0; in_d = 1'b0;
        check_ctl({tag, " snap"}, 0, 1, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_ctl($sformatf("%s w%0d", tag, i), 1, 1, 0);
            check_word(tag, i, exp[i]);
            if (i == stall_idx) begin
                rpt_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check_ctl($sformatf("%s stall%0d", tag, s), 1, 1, 0);
                    check_word({tag, " stall"}, i, exp[i]);
                end
                rpt_ready = 1'b1;
            end
            step();
        end
        if (clr) begin
            check_ctl({tag, " clr"}, 0, 1, 0);
            check({tag, " clr idx8"}, int'(rpt_idx8), 0);
            check({tag, " clr data8"}, int'(rpt_data8), 0);
            step();
        end
        check_ctl({tag, " end"}, 0, 0, 1);
        check({tag, " end idx8"}, int'(rpt_idx8), 0);
        check({tag, " end data8"}, int'(rpt_data8), 0);
    endtask

    initial begin
        logic [15:0] prime_mask;
        logic [15:0] div3_mask;
        prime_mask = 16'h28AC;  // 2,3,5,7,11,13
        div3_mask  = 16'h9249;  // 0,3,6,9,12,15

        #12;
        check_ctl("reset", 0, 1'b0, 1);
        rst_n = 1'b1;
        step();
        check_ctl("post reset", 0, 0, 1);
        check("post reset idx8", int'(rpt_idx8), 0);
        check("post reset data8", int'(rpt_data8), 0);

        // All 16 nibbles with correct flags.
        for (int v = 0; v < 16; v++) send_beat(4'(v), prime_mask[v], div3_mask[v]);
        read_report("sweep", 16, 6, 6, 1, 2, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        // Counters survive a non-clearing report; this one clears afterwards.
        read_report("sweep again", 16, 6, 6, 1, 2, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        read_report("after clear", 0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        // Beat in the same cycle as the request is included.
        read_report("same cycle", 1, 1, 0, 0, 1, 1'b1, -1, 1'b1, 1'b1, 1'b0);

        // 20 primes divisible by 3: CW=8 reads 20, CW=4 saturates at 15.
        for (int k = 0; k < 20; k++) send_beat(4'd3, 1'b1, 1'b1);
        // Stall three cycles at word 2, then clear.
        read_report("saturate", 20, 20, 20, 20, 20, 1'b1, 2, 1'b0, 1'b0, 1'b0);

        // Reset asserted while sending word 2.
        send_beat(4'd7, 1'b1, 1'b0);
        send_beat(4'd9, 1'b0, 1'b1);
        rpt_req = 1'b1; rpt_ready = 1'b1;
        step();
        rpt_req = 1'b0;
        step();
        step();
        step();
        check_word("pre abort", 2, 1);
        rpt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_ctl("abort", 0, 0, 1);
        check("abort idx8", int'(rpt_idx8), 0);
        check("abort data8", int'(rpt_data8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_ctl("after abort", 0, 0, 1);
        read_report("after abort", 0, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_class_stats.md
Name: nibble_class_stats

Overview:
- Downstream consumer of the 4-bit nibble classifier.
- Takes a valid/ready stream of nibbles together with their prime flag (p) and divisible-by-3 flag (d).
- Keeps saturating event statistics: total, primes, multiples of 3, both, and longest consecutive-prime run.
- On request, freezes input and reads the statistics out as a 5-word sequence over a valid/ready report port, with optional clear-after-read.

Parameters:
- CW, 8, width of every statistics counter and of rpt_data (CW >= 3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_val  input  4  nibble value; carried for debug only, not used in the statistics.
- in_p  input  1  classifier prime flag for in_val.
- in_d  input  1  classifier divisible-by-3 flag for in_val.
- rpt_req  input  1  report request (level sampled in IDLE).
- rpt_clr  input  1  clear statistics after report; sampled with rpt_req.
- rpt_valid  output  1  report word valid.
- rpt_ready  input  1  report consumer ready.
- rpt_idx  output  3  report word index, 0..4.
- rpt_data  output  CW  report word.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All counters, cur_run, snapshot regs and clr_lat = 0.
  - rpt_valid=0, rpt_idx=0, rpt_data=0, busy=0, in_ready=1 once out of reset.
  - Assertion mid-report aborts the report immediately; no partial clear.
- Input acceptance:
  - in_ready = (state==IDLE), combinational from state only.
  - A beat is accepted when in_valid & in_ready. Counter updates are visible the following cycle.
- Statistics per accepted beat. All counters saturate at 2^CW-1; there is no wrap.
  - tot += 1.
  - prm += in_p.
  - div += in_d.
  - both += in_p & in_d.
  - in_p=1: cur_run = sat(cur_run+1); max_run = max(max_run, sat(cur_run+1)).
  - in_p=0: cur_run = 0; max_run unchanged.
- FSM states: IDLE, SNAP, SEND, CLR.
  - IDLE: if rpt_req, latch clr_lat <= rpt_clr and go to SNAP. A beat accepted in the same cycle as rpt_req is counted and included in the report.
  - SNAP (1 cycle): copy tot, prm, div, both, max_run into snapshot regs; set rpt_idx=0; go to SEND.
  - SEND:
    - rpt_valid=1; rpt_data = snapshot word for rpt_idx: 0=tot, 1=prm, 2=div, 3=both, 4=max_run.
    - On rpt_valid & rpt_ready: if rpt_idx<4, rpt_idx += 1. If rpt_idx==4, rpt_valid drops next cycle and the FSM goes to CLR if clr_lat, else IDLE.
    - While rpt_ready=0, rpt_idx and rpt_data are held stable.
  - CLR (1 cycle): zero tot, prm, div, both, max_run, cur_run and clr_lat; go to IDLE. Snapshot regs are kept.
- rpt_req is ignored outside IDLE. Holding rpt_req high at the return to IDLE starts a new report immediately; this is legal.
- rpt_data and rpt_idx are registered. rpt_data = 0 and rpt_idx = 0 when rpt_valid=0.
- in_p/in_d are trusted as given; the block performs no recomputation.
- Latency:
  - rpt_req high in IDLE (cycle N) -> SNAP (N+1) -> first rpt_valid at N+2.
  - Minimum report duration is 5 cycles with rpt_ready held high.
  - in_ready returns 1 the cycle after the last handshake, or one cycle later with clear.

Test Plan:
- Stream nibbles 0..15 once, correct flags, rpt_ready=1, then rpt_req -> words idx0..4 = 16, 6, 6, 1, 2 (primes 2,3,5,7,11,13; multiples 0,3,6,9,12,15; both=3; run {2,3}=2).
- CW=4, 20 beats of value 3 (p=1, d=1) -> report 15, 15, 15, 15, 15; no wrap to small values.
- Report with rpt_ready low for 3 cycles at idx 2 -> rpt_idx=2 and rpt_data=div held constant, rpt_valid held 1; sequence then resumes at 3; in_ready=0 throughout.
- After data, rpt_req with rpt_clr=1 -> normal report, one CLR cycle, then a second report reads 0, 0, 0, 0, 0; second report with rpt_clr=0 leaves counters intact.
- In IDLE, same cycle: in_valid=1 (val 5, p=1, d=0) and rpt_req=1, from clear state -> beat accepted; report 1, 1, 0, 0, 1.
- Assert rst_n low while in SEND at idx 2 -> rpt_valid=0 and busy=0 immediately; after release in_ready=1 and a new report reads all zeros.
